// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache, one word per line, refilled from instruction
// memory on a miss through a req/ack handshake; includes flush and saturating hit/miss counters.
module icache_dm_refill #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SETS    = 16,
  parameter int OFFSET_BITS = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_valid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int BLOCK_BITS = ADDR_WIDTH - OFFSET_BITS;
  localparam int TAG_BITS   = BLOCK_BITS - INDEX_BITS;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{BLOCK_BITS{1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  stall_q, stall_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic                  refill_we;

  logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

  logic [INDEX_BITS-1:0] idx_in, idx_lat;
  logic [TAG_BITS-1:0]   tag_in, tag_lat;
  logic                  lookup_hit;

  // The latched miss address doubles as the refill target, so no separate pc copy is kept.
  assign idx_in  = pc[OFFSET_BITS +: INDEX_BITS];
  assign tag_in  = pc[ADDR_WIDTH-1 -: TAG_BITS];
  assign idx_lat = mem_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign tag_lat = mem_addr_q[ADDR_WIDTH-1 -: TAG_BITS];

  // A flush in the lookup cycle forces a miss even if the line was valid.
  assign lookup_hit = valid_q[idx_in] && (tag_mem[idx_in] == tag_in) && !flush;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    stall_d       = stall_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    flush_pend_d  = flush_pend_q;
    valid_d       = valid_q;
    refill_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush) valid_d = '0;
        if (pc_valid) begin
          if (lookup_hit) begin
            instr_d       = data_mem[idx_in];
            instr_valid_d = 1'b1;
            hit_cnt_d     = sat_inc(hit_cnt_q);
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc & ALIGN_MASK;
            stall_d    = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          refill_we        = 1'b1;
          valid_d[idx_lat] = 1'b1;
          instr_d          = mem_data;
          mem_req_d        = 1'b0;
          state_d          = RESPOND;
        end
      end
      RESPOND: begin
        instr_valid_d = 1'b1;
        stall_d       = 1'b0;
        flush_pend_d  = 1'b0;
        state_d       = IDLE;
        // A flush seen at any point of the refill wipes everything, including the new line.
        if (flush || flush_pend_q) valid_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      flush_pend_q  <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      stall_q       <= stall_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      flush_pend_q  <= flush_pend_d;
      valid_q       <= valid_d;
    end
  end

  // NOTE: tag/data arrays have no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clock) begin
    if (refill_we) begin
      tag_mem[idx_lat]  <= tag_lat;
      data_mem[idx_lat] <= mem_data;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign stall       = stall_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Bench for icache_dm_refill: directed and random fetches against a line-level cache model,
// with a second CNT_WIDTH=4 instance sharing the stimulus to exercise counter saturation.
module tb_icache_dm_refill;

  localparam int OB = 3;
  localparam int NS = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid, flush, mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instruction, mem_addr;
  logic        instr_valid, stall, mem_req;
  logic [15:0] hit_count, miss_count;
  logic [31:0] s_instruction, s_mem_addr;
  logic        s_instr_valid, s_stall, s_mem_req;
  logic [3:0]  s_hit_count, s_miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: which block address each set holds, the backing memory image, event counts.
  bit          line_v   [NS];
  int unsigned line_blk [NS];
  logic [31:0] mem_img  [int unsigned];
  int          n_hits, n_miss;

  always #5 clock = ~clock;

  icache_dm_refill dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_dm_refill #(.CNT_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .instruction(s_instruction), .instr_valid(s_instr_valid), .stall(s_stall),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_img.exists(a)) mem_img[a] = $urandom;
    return mem_img[a];
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) line_v[i] = 1'b0;
  endtask

  task automatic check_counts();
    check("hit_count", hit_count, 64'(sat(n_hits, 65535)));
    check("miss_count", miss_count, 64'(sat(n_miss, 65535)));
    check("sat_hit_count", s_hit_count, 64'(sat(n_hits, 15)));
    check("sat_miss_count", s_miss_count, 64'(sat(n_miss, 15)));
  endtask

  // fl: 0 = plain fetch, 1 = flush in the request cycle, 2 = flush during the refill (delay >= 1).
  task automatic fetch(input logic [31:0] a, input int delay, input int fl);
    int unsigned blk;
    int          idx;
    bit          exp_hit;
    logic [31:0] aligned, word;
    blk     = a >> OB;
    idx     = int'(blk % NS);
    aligned = a & ~32'(7);
    word    = mem_word(aligned);
    if (fl == 1) model_clear();
    exp_hit = line_v[idx] && (line_blk[idx] == blk);

    @(negedge clock);
    pc = a; pc_valid = 1'b1; flush = (fl == 1);
    @(posedge clock); #1;
    flush = 1'b0;
    if (exp_hit) begin
      pc_valid = 1'b0;
      n_hits++;
      check("hit_valid", instr_valid, 1);
      check("hit_data", instruction, word);
      check("hit_no_req", mem_req, 0);
      check("hit_no_stall", stall, 0);
      @(posedge clock); #1;
      check("hit_pulse_one_cycle", instr_valid, 0);
    end else begin
      n_miss++;
      check("miss_req", mem_req, 1);
      check("miss_stall", stall, 1);
      check("miss_addr", mem_addr, aligned);
      check("miss_no_valid", instr_valid, 0);
      pc = $urandom;
      for (int i = 0; i < delay; i++) begin
        if (fl == 2 && i == 0) flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("refill_hold_req", mem_req, 1);
        check("refill_hold_addr", mem_addr, aligned);
        check("refill_no_valid", instr_valid, 0);
      end
      @(negedge clock);
      mem_ack = 1'b1; mem_data = word;
      @(posedge clock); #1;
      mem_ack = 1'b0; mem_data = $urandom;
      check("respond_req_low", mem_req, 0);
      check("respond_stall", stall, 1);
      check("respond_no_valid_yet", instr_valid, 0);
      @(posedge clock); #1;
      pc_valid = 1'b0;
      check("miss_valid", instr_valid, 1);
      check("miss_data", instruction, word);
      check("miss_stall_drop", stall, 0);
      line_v[idx] = 1'b1; line_blk[idx] = blk;
      if (fl == 2) model_clear();
    end
    check_counts();
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    model_clear();
    check("flush_no_valid", instr_valid, 0);
  endtask

  initial begin
    reset = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
    n_hits = 0; n_miss = 0;
    model_clear();
    mem_img[32'h100] = 32'h910006D6;
    mem_img[32'h180] = 32'hCB0600C6;
    repeat (2) @(posedge clock);
    #1;
    check("rst_instruction", instruction, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check_counts();
    @(negedge clock);
    reset = 1'b0;

    // Cold miss, hit, conflict eviction.
    fetch(32'h100, 3, 0);
    fetch(32'h100, 0, 0);
    fetch(32'h180, 2, 0);
    fetch(32'h100, 1, 0);
    check("conflict_miss_count", miss_count, 3);

    // Warm 0x100..0x168, re-read as hits, then flush variants.
    for (int a = 32'h100; a <= 32'h168; a += 8) fetch(32'(a), int'($urandom_range(0, 3)), 0);
    for (int a = 32'h100; a <= 32'h168; a += 8) fetch(32'(a), 0, 0);
    do_flush();
    fetch(32'h108, 1, 0);
    fetch(32'h100, 0, 1);
    fetch(32'h118, 2, 2);
    fetch(32'h118, 1, 0);
    fetch(32'h100, 1, 0);

    // Reset in the middle of a refill; the late ack must not fill the line.
    @(negedge clock);
    pc = 32'h300; pc_valid = 1'b1;
    @(posedge clock); #1;
    check("pre_reset_req", mem_req, 1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    pc_valid = 1'b0;
    check("midreset_req", mem_req, 0);
    check("midreset_stall", stall, 0);
    model_clear();
    n_hits = 0; n_miss = 0;
    check_counts();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check("late_ack_no_valid", instr_valid, 0);
    check("late_ack_no_stall", stall, 0);
    @(posedge clock); #1;
    check("late_ack_no_valid2", instr_valid, 0);
    fetch(32'h300, 1, 0);

    // Saturation: the 4-bit instance must pin at 15.
    for (int i = 0; i < 20; i++) fetch(32'h304, 0, 0);
    check("sat_hit_15", s_hit_count, 15);

    // Random fetches over a small address window to mix hits and conflicts.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 15) == 0) do_flush();
      fetch(32'($urandom_range(0, 511)), int'($urandom_range(1, 4)), int'($urandom_range(0, 9) == 0 ? 2 : 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
